// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: scheduler states, default sizes and Q15 saturation shared by the FIR MAC scheduler.
package fir_sched_pkg;
    localparam int TAPS_D = 32;
    localparam int DW_D = 16;
    localparam int AW_D = 5;
    localparam int ACC_W = 2 * DW_D + AW_D;
    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DW_D - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DW_D - 1));

    typedef enum logic [2:0] {IDLE, LOAD, MAC0, MAC1, DONE} state_t;

    // Arithmetic shift floors toward -inf, so no rounding is applied.
    function automatic logic signed [DW_D-1:0] sat_q15(input logic signed [63:0] a);
        logic signed [63:0] s;
        s = a >>> (DW_D - 1);
        if (s > SAT_MAX) return SAT_MAX[DW_D-1:0];
        if (s < SAT_MIN) return SAT_MIN[DW_D-1:0];
        return s[DW_D-1:0];
    endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate with clear/enable and saturated Q15 view of acc + product.
module fir_mac
    import fir_sched_pkg::*;
#(
    parameter int DW = DW_D,
    parameter int ACC = ACC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] y
);
    logic signed [2*DW-1:0] prod;
    logic signed [ACC-1:0] acc;
    logic signed [ACC-1:0] sum;

    // y includes the product being accumulated this cycle so the last tap lands in the result.
    always_comb begin
        prod = a * b;
        sum = acc + {{(ACC - 2 * DW){prod[2*DW-1]}}, prod};
        y = sat_q15({{(64 - ACC){sum[ACC-1]}}, sum});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= sum;
    end
endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: runs the two voice-path FIR passes per frame on one shared MAC against a
// one-cycle-latency coefficient ROM.
module fir_mac_sched
    import fir_sched_pkg::*;
#(
    parameter int TAPS = TAPS_D,
    parameter int DW = DW_D,
    parameter int AW = AW_D
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample,
    input  logic signed [DW-1:0] x0,
    input  logic signed [DW-1:0] x1,
    output logic [AW:0]          coef_addr,
    input  logic signed [DW-1:0] coef,
    output logic signed [DW-1:0] y0,
    output logic signed [DW-1:0] y1,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam logic [AW:0] K_LAST = (AW + 1)'(TAPS);

    state_t state, nxt;
    logic [AW-1:0] wp;
    logic [AW:0] k;
    logic signed [DW-1:0] xs0, xs1, tap, hold, mac_y;
    logic signed [DW-1:0] d0 [TAPS];
    logic signed [DW-1:0] d1 [TAPS];
    logic mac, last, accept;

    always_comb begin
        mac = (state == MAC0) || (state == MAC1);
        last = mac && (k == K_LAST);
        accept = sample && ((state == IDLE) || (state == DONE));
        busy = (state == LOAD) || mac;
        overrun = sample && busy;
        y_valid = state == DONE;
        coef_addr = (mac && !k[AW]) ? {state == MAC1, k[AW-1:0]} : '0;
        nxt = state;
        case (state)
            IDLE: nxt = sample ? LOAD : IDLE;
            LOAD: nxt = MAC0;
            MAC0: nxt = last ? MAC1 : MAC0;
            MAC1: nxt = last ? DONE : MAC1;
            DONE: nxt = sample ? LOAD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wp <= '0;
            k <= '0;
            xs0 <= '0;
            xs1 <= '0;
            tap <= '0;
            hold <= '0;
            y0 <= '0;
            y1 <= '0;
            for (int i = 0; i < TAPS; i++) begin
                d0[i] <= '0;
                d1[i] <= '0;
            end
        end else begin
            state <= nxt;
            if (accept) begin
                xs0 <= x0;
                xs1 <= x1;
            end
            if (state == LOAD) begin
                d0[wp + 1'b1] <= xs0;
                d1[wp + 1'b1] <= xs1;
                wp <= wp + 1'b1;
            end
            k <= (mac && !last) ? k + 1'b1 : '0;
            // Tap k is registered alongside its ROM read so both meet at the MAC next cycle.
            if (mac && !k[AW]) tap <= (state == MAC1) ? d1[wp - k[AW-1:0]] : d0[wp - k[AW-1:0]];
            if (state == MAC0 && last) hold <= mac_y;
            if (state == MAC1 && last) begin
                y0 <= hold;
                y1 <= mac_y;
            end
        end
    end

    fir_mac #(.DW(DW), .ACC(2 * DW + AW)) u_mac (
        .clk(clk),
        .reset(reset),
        .clr((state == LOAD) || last),
        .en(mac && (k != '0)),
        .a(tap),
        .b(coef),
        .y(mac_y)
    );
endmodule
